// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared state enums and default constants for the UART boot loader.
package prog_loader_pkg;
  typedef enum logic [2:0] {IDLE, CNT_LO, CNT_HI, DATA, CSUM, DONE, ERR} ld_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
  localparam int BAUD_DIV = 868;
  localparam int TIMEOUT_DEFAULT = 2**20;
endpackage

// File: rtl/prog_loader_if.sv
// prog_loader_if: serial input, imem write port and core control of the boot loader.
interface prog_loader_if #(parameter int ADDR_W = 12);
  logic rxd;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0] imem_wdata;
  logic imem_we, cpu_rst, done, err;
  modport master (input rxd, output imem_addr, imem_wdata, imem_we, cpu_rst, done, err);
  modport slave (output rxd, input imem_addr, imem_wdata, imem_we, cpu_rst, done, err);
endinterface

// File: rtl/prog_loader_uart_rx.sv
// prog_loader_uart_rx: 8N1 receiver, start re-checked at half bit, data/stop sampled mid-bit.
module prog_loader_uart_rx import prog_loader_pkg::*; #(
  parameter int CLKS_PER_BIT = BAUD_DIV
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  rx_state_t st_q, st_d;
  logic [2:0] sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sh_q, sh_d;
  assign rx_data = sh_q;
  // sync_q[1] is the synchronised line, sync_q[2] its previous value for edge detection
  always_comb begin
    st_d = st_q;
    cnt_d = cnt_q + 1'b1;
    bit_d = bit_q;
    sh_d = sh_q;
    rx_valid = 1'b0;
    frame_err = 1'b0;
    case (st_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (sync_q[2] && !sync_q[1]) st_d = RX_START;
      end
      RX_START: if (cnt_q == HALF) begin
        cnt_d = '0;
        bit_d = '0;
        st_d = sync_q[1] ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (cnt_q == LAST) begin
        cnt_d = '0;
        sh_d = {sync_q[1], sh_q[7:1]};
        bit_d = bit_q + 1'b1;
        if (bit_q == 3'd7) st_d = RX_STOP;
      end
      RX_STOP: if (cnt_q == LAST) begin
        st_d = RX_IDLE;
        rx_valid = sync_q[1];
        frame_err = !sync_q[1];
      end
      default: st_d = RX_IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      st_q <= RX_IDLE;
      sync_q <= 3'b111;
      cnt_q <= '0;
      bit_q <= '0;
      sh_q <= '0;
    end else begin
      st_q <= st_d;
      sync_q <= {sync_q[1:0], rxd};
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      sh_q <= sh_d;
    end
endmodule

// File: rtl/prog_loader.sv
// prog_loader: UART boot loader writing a framed image to imem and holding the core in reset.
// Define PROG_LOADER_CSUM_EN to require a trailing XOR checksum byte.
module prog_loader import prog_loader_pkg::*; #(
  parameter int CLKS_PER_BIT = BAUD_DIV,
  parameter int ADDR_W = 12,
  parameter logic [7:0] SYNC_BYTE = SYNC_DEFAULT,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input logic clk,
  input logic rst,
  prog_loader_if.master bus
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);
  localparam logic [16:0] NMAX = 17'(2**ADDR_W);
`ifdef PROG_LOADER_CSUM_EN
  localparam ld_state_t FIN = CSUM;
  logic [7:0] csum_q, csum_d;
`else
  localparam ld_state_t FIN = DONE;
`endif
  ld_state_t st_q, st_d;
  logic [15:0] n_q, n_d, k_q, k_d;
  logic [1:0] bc_q, bc_d;
  logic [31:0] word_q, word_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic we_q, we_d, done_q, done_d, err_q, err_d, cpu_rst_q, cpu_rst_d;
  logic [7:0] rx_data;
  logic rx_valid, frame_err, active;
  prog_loader_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk(clk), .rst(rst), .rxd(bus.rxd),
    .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err)
  );
  assign bus.imem_addr = k_q[ADDR_W-1:0];
  assign bus.imem_wdata = word_q;
  assign bus.imem_we = we_q;
  assign bus.done = done_q;
  assign bus.err = err_q;
  assign bus.cpu_rst = cpu_rst_q;
  always_comb begin
    active = st_q inside {CNT_LO, CNT_HI, DATA, CSUM};
    st_d = st_q;
    n_d = n_q;
    k_d = k_q;
    bc_d = bc_q;
    word_d = word_q;
    we_d = 1'b0;
    tmo_d = (rx_valid || !active) ? '0 : (tmo_q == TMAX) ? tmo_q : tmo_q + 1'b1;
`ifdef PROG_LOADER_CSUM_EN
    csum_d = (rx_valid && st_q inside {CNT_LO, CNT_HI, DATA}) ? csum_q ^ rx_data : csum_q;
`endif
    case (st_q)
      IDLE, DONE, ERR: if (rx_valid && rx_data == SYNC_BYTE) begin
        st_d = CNT_LO;
        k_d = '0;
        bc_d = '0;
`ifdef PROG_LOADER_CSUM_EN
        csum_d = '0;
`endif
      end
      CNT_LO: if (rx_valid) begin
        n_d = {n_q[15:8], rx_data};
        st_d = CNT_HI;
      end
      CNT_HI: if (rx_valid) begin
        n_d = {rx_data, n_q[7:0]};
        st_d = ({1'b0, n_d} > NMAX) ? ERR : (n_d == '0) ? FIN : DATA;
      end
      // the write cycle advances the word index; bytes never arrive back-to-back with it
      DATA: if (we_q) begin
        k_d = k_q + 1'b1;
        if (k_q == n_q - 1'b1) st_d = FIN;
      end else if (rx_valid) begin
        word_d = {rx_data, word_q[31:8]};
        bc_d = bc_q + 1'b1;
        we_d = bc_q == 2'd3;
      end
`ifdef PROG_LOADER_CSUM_EN
      CSUM: if (rx_valid) st_d = (rx_data == csum_q) ? DONE : ERR;
`endif
      default: ;
    endcase
    if (active && (frame_err || tmo_q == TMAX)) st_d = ERR;
    done_d = st_d == DONE;
    err_d = st_d == ERR;
    cpu_rst_d = st_d != DONE;
  end
  always_ff @(posedge clk)
    if (rst) begin
      st_q <= IDLE;
      n_q <= '0;
      k_q <= '0;
      bc_q <= '0;
      word_q <= '0;
      tmo_q <= '0;
      we_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      cpu_rst_q <= 1'b1;
`ifdef PROG_LOADER_CSUM_EN
      csum_q <= '0;
`endif
    end else begin
      st_q <= st_d;
      n_q <= n_d;
      k_q <= k_d;
      bc_q <= bc_d;
      word_q <= word_d;
      tmo_q <= tmo_d;
      we_q <= we_d;
      done_q <= done_d;
      err_q <= err_d;
      cpu_rst_q <= cpu_rst_d;
`ifdef PROG_LOADER_CSUM_EN
      csum_q <= csum_d;
`endif
    end
endmodule
